// File: rtl/wb_commit_queue_if.sv
// MEM -> WB handoff bundle: one queue entry offered per cycle with a valid/allowin handshake.
interface wb_commit_queue_if #(
   parameter int DATA_W = 32,
   parameter int NEXC   = 6
);
   logic              ms2ws_valid;
   logic              ws_allowin;
   logic [31:0]       ms_pc;
   logic [31:0]       ms_vaddr;
   logic              ms_rf_we;
   logic [4:0]        ms_rf_waddr;
   logic [DATA_W-1:0] ms_rf_wdata;
   logic              ms_csr_re;
   logic [NEXC-1:0]   ms_exc;
   logic              ms_ertn;
   logic              ms_refetch;

   modport master (
      output ms2ws_valid, ms_pc, ms_vaddr, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
             ms_csr_re, ms_exc, ms_ertn, ms_refetch,
      input  ws_allowin
   );

   modport slave (
      input  ms2ws_valid, ms_pc, ms_vaddr, ms_rf_we, ms_rf_waddr, ms_rf_wdata,
             ms_csr_re, ms_exc, ms_ertn, ms_refetch,
      output ws_allowin
   );
endinterface

// File: rtl/wb_commit_queue.sv
// In-order writeback commit queue: entries retire from the head into the register file,
// and a faulting/ertn/refetch head raises a one-cycle flush that empties the queue.
module wb_commit_queue #(
   parameter int                DEPTH     = 2,
   parameter int                DATA_W    = 32,
   parameter int                NEXC      = 6,
   parameter logic [6*NEXC-1:0] ECODE_TAB = {6'hd, 6'hc, 6'hb, 6'h9, 6'h8, 6'h0}
) (
   input  logic                    clk,
   input  logic                    resetn,
   wb_commit_queue_if.slave        ms_if,
   input  logic                    commit_ready,
   output logic                    csr_re,
   input  logic [DATA_W-1:0]       csr_rvalue,
   output logic                    rf_we,
   output logic [4:0]              rf_waddr,
   output logic [DATA_W-1:0]       rf_wdata,
   output logic [31:0]             debug_wb_pc,
   output logic [3:0]              debug_wb_rf_we,
   output logic [4:0]              debug_wb_rf_wnum,
   output logic [DATA_W-1:0]       debug_wb_rf_wdata,
   output logic                    wb_ex,
   output logic                    ertn_flush,
   output logic                    wb_refetch_flush,
   output logic [5:0]              wb_ecode,
   output logic [8:0]              wb_esubcode,
   output logic [31:0]             wb_pc,
   output logic [31:0]             wb_vaddr,
   output logic [$clog2(DEPTH):0]  ws_count
);
   localparam int             PW   = $clog2(DEPTH);
   localparam int             CW   = PW + 1;
   localparam logic [CW-1:0]  FULL = CW'(DEPTH);

   logic [31:0]       q_pc      [DEPTH];
   logic [31:0]       q_vaddr   [DEPTH];
   logic              q_rf_we   [DEPTH];
   logic [4:0]        q_waddr   [DEPTH];
   logic [DATA_W-1:0] q_wdata   [DEPTH];
   logic              q_csr_re  [DEPTH];
   logic [NEXC-1:0]   q_exc     [DEPTH];
   logic              q_ertn    [DEPTH];
   logic              q_refetch [DEPTH];

   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;

   logic            head_valid, commit, any_exc, flush, push, pop;
   logic [NEXC-1:0] h_exc;
   logic [5:0]      ecode;

   assign head_valid = (count != '0);
   assign commit     = head_valid & commit_ready;
   assign h_exc      = q_exc[head];
   assign any_exc    = |h_exc;

   assign wb_ex            = commit & any_exc;
   assign ertn_flush       = commit & q_ertn[head] & ~any_exc;
   assign wb_refetch_flush = commit & q_refetch[head] & ~any_exc & ~q_ertn[head];
   assign flush            = wb_ex | ertn_flush | wb_refetch_flush;

   // Allowin looks only at occupancy, so a full queue refuses even when the head retires.
   assign ms_if.ws_allowin = (count != FULL);
   assign push = ms_if.ms2ws_valid & ms_if.ws_allowin & ~flush;
   assign pop  = commit & ~flush;

   // Scan from the lowest-priority source down so the lowest set index wins.
   always_comb begin
      ecode = '0;
      for (int i = NEXC - 1; i >= 0; i--) begin
         if (h_exc[i]) ecode = ECODE_TAB[6*i +: 6];
      end
   end

   assign wb_ecode    = head_valid ? ecode : 6'd0;
   assign wb_esubcode = '0;
   assign wb_pc       = head_valid ? q_pc[head]    : 32'd0;
   assign wb_vaddr    = head_valid ? q_vaddr[head] : 32'd0;

   assign csr_re   = head_valid & q_csr_re[head];
   assign rf_we    = commit & q_rf_we[head] & ~any_exc & ~q_ertn[head];
   assign rf_waddr = q_waddr[head];
   assign rf_wdata = q_csr_re[head] ? csr_rvalue : q_wdata[head];

   assign debug_wb_pc       = q_pc[head];
   assign debug_wb_rf_we    = {4{rf_we}};
   assign debug_wb_rf_wnum  = rf_waddr;
   assign debug_wb_rf_wdata = rf_wdata;
   assign ws_count          = count;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i]      <= '0;
            q_vaddr[i]   <= '0;
            q_rf_we[i]   <= 1'b0;
            q_waddr[i]   <= '0;
            q_wdata[i]   <= '0;
            q_csr_re[i]  <= 1'b0;
            q_exc[i]     <= '0;
            q_ertn[i]    <= 1'b0;
            q_refetch[i] <= 1'b0;
         end
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (push) begin
            q_pc[tail]      <= ms_if.ms_pc;
            q_vaddr[tail]   <= ms_if.ms_vaddr;
            q_rf_we[tail]   <= ms_if.ms_rf_we;
            q_waddr[tail]   <= ms_if.ms_rf_waddr;
            q_wdata[tail]   <= ms_if.ms_rf_wdata;
            q_csr_re[tail]  <= ms_if.ms_csr_re;
            q_exc[tail]     <= ms_if.ms_exc;
            q_ertn[tail]    <= ms_if.ms_ertn;
            q_refetch[tail] <= ms_if.ms_refetch;
            tail            <= tail + PW'(1);
         end
         if (pop) head <= head + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue against a queue-based reference model.
module tb_wb_commit_queue;
   localparam int DEPTH = 2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] vaddr;
      logic        we;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic        csr;
      logic [5:0]  exc;
      logic        ertn;
      logic        refetch;
   } ent_t;

   logic        clk, resetn, commit_ready, csr_re, rf_we;
   logic [31:0] csr_rvalue, rf_wdata, debug_wb_pc, debug_wb_rf_wdata, wb_pc, wb_vaddr;
   logic [4:0]  rf_waddr, debug_wb_rf_wnum;
   logic [3:0]  debug_wb_rf_we;
   logic        wb_ex, ertn_flush, wb_refetch_flush;
   logic [5:0]  wb_ecode;
   logic [8:0]  wb_esubcode;
   logic [1:0]  ws_count;

   int errors = 0;
   int checks = 0;
   ent_t mq[$];

   wb_commit_queue_if #(.DATA_W(32), .NEXC(6)) ms_if ();

   wb_commit_queue #(.DEPTH(DEPTH), .DATA_W(32), .NEXC(6)) dut (
      .clk(clk), .resetn(resetn), .ms_if(ms_if), .commit_ready(commit_ready),
      .csr_re(csr_re), .csr_rvalue(csr_rvalue), .rf_we(rf_we), .rf_waddr(rf_waddr),
      .rf_wdata(rf_wdata), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
      .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
      .wb_ex(wb_ex), .ertn_flush(ertn_flush), .wb_refetch_flush(wb_refetch_flush),
      .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
      .ws_count(ws_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // LoongArch ecodes in priority order: int, adef, ale, sys, brk, ine.
   function automatic logic [5:0] exp_ecode(input logic [5:0] exc);
      for (int i = 0; i < 6; i++) begin
         if (exc[i]) begin
            case (i)
               0: return 6'h0;
               1: return 6'h8;
               2: return 6'h9;
               3: return 6'hb;
               4: return 6'hc;
               default: return 6'hd;
            endcase
         end
      end
      return 6'h0;
   endfunction

   function automatic ent_t mk(input int idx);
      ent_t e;
      e = '0;
      e.pc    = 32'h1c00_0000 + 32'(idx * 4);
      e.vaddr = $urandom;
      e.we    = 1'b1;
      e.waddr = 5'(idx);
      e.wdata = $urandom;
      return e;
   endfunction

   task automatic offer(input logic v, input ent_t e);
      ms_if.ms2ws_valid = v;
      ms_if.ms_pc       = e.pc;
      ms_if.ms_vaddr    = e.vaddr;
      ms_if.ms_rf_we    = e.we;
      ms_if.ms_rf_waddr = e.waddr;
      ms_if.ms_rf_wdata = e.wdata;
      ms_if.ms_csr_re   = e.csr;
      ms_if.ms_exc      = e.exc;
      ms_if.ms_ertn     = e.ertn;
      ms_if.ms_refetch  = e.refetch;
   endtask

   // Advance one clock and apply the same edge to the reference queue.
   task automatic tick();
      bit   cm, fl, acc;
      ent_t h, e;
      h  = (mq.size() != 0) ? mq[0] : '0;
      cm = (mq.size() != 0) && commit_ready;
      fl = cm && (h.exc != 0 || h.ertn || h.refetch);
      acc = ms_if.ms2ws_valid && (mq.size() < DEPTH) && !fl;
      e = '{ms_if.ms_pc, ms_if.ms_vaddr, ms_if.ms_rf_we, ms_if.ms_rf_waddr, ms_if.ms_rf_wdata,
             ms_if.ms_csr_re, ms_if.ms_exc, ms_if.ms_ertn, ms_if.ms_refetch};
      @(posedge clk);
      if (fl) mq.delete();
      else begin
         if (cm) mq.delete(0);
         if (acc) mq.push_back(e);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      commit_ready = 1'b1;
      offer(1'b0, '0);
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if ({ms_if.ws_allowin, ws_count} !== 3'b100) begin
         errors++; $display("FAIL reset_allowin_count: got %b expected 100", {ms_if.ws_allowin, ws_count});
      end
      checks++;
      if ({wb_ex, ertn_flush, wb_refetch_flush, rf_we, csr_re, debug_wb_rf_we} !== 9'd0) begin
         errors++; $display("FAIL reset_pulses: got %b expected 0",
                            {wb_ex, ertn_flush, wb_refetch_flush, rf_we, csr_re, debug_wb_rf_we});
      end
      checks++;
      if ({wb_pc, wb_vaddr, debug_wb_pc, rf_wdata, wb_ecode, wb_esubcode, rf_waddr} !== '0) begin
         errors++; $display("FAIL reset_data: pc=%h vaddr=%h dpc=%h wdata=%h ecode=%h",
                            wb_pc, wb_vaddr, debug_wb_pc, rf_wdata, wb_ecode);
      end
      resetn = 1'b1;
      mq.delete();
      tick();
      #1;
      checks++;
      if ({ms_if.ws_allowin, ws_count, wb_ex, rf_we, csr_re} !== 6'b100000) begin
         errors++; $display("FAIL idle_after_reset: got %b expected 100000",
                            {ms_if.ws_allowin, ws_count, wb_ex, rf_we, csr_re});
      end
   endtask

   task automatic test_streaming();
      int writes = 0;
      commit_ready = 1'b1;
      for (int cyc = 0; cyc < 12; cyc++) begin
         ent_t e;
         e = mk(cyc);
         e.wdata = 32'h100 + 32'(cyc);
         offer(cyc < 8, e);
         #1;
         checks++;
         if (ws_count > 2'd1) begin
            errors++; $display("FAIL stream_count: got %0d expected <=1", ws_count);
         end
         if (mq.size() != 0) begin
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(writes) || rf_wdata !== 32'h100 + 32'(writes)
                || debug_wb_rf_we !== 4'hf) begin
               errors++; $display("FAIL stream_write: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=%h",
                                  rf_we, rf_waddr, rf_wdata, writes, 32'h100 + 32'(writes));
            end
            writes++;
         end
         tick();
      end
      checks++;
      if (writes != 8) begin
         errors++; $display("FAIL stream_total: got %0d expected 8", writes);
      end
   endtask

   task automatic test_backpressure();
      commit_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         offer(1'b1, mk(10 + i));
         #1;
         checks++;
         if (ms_if.ws_allowin !== 1'b1) begin
            errors++; $display("FAIL bp_accept%0d: got allowin=%b expected 1", i, ms_if.ws_allowin);
         end
         tick();
      end
      offer(1'b1, mk(12));
      #1;
      checks++;
      if ({ms_if.ws_allowin, ws_count} !== 3'b010) begin
         errors++; $display("FAIL bp_full: got allowin/count=%b expected 010", {ms_if.ws_allowin, ws_count});
      end
      tick();
      commit_ready = 1'b1;
      #1;
      checks++;
      if ({ms_if.ws_allowin, rf_we, rf_waddr} !== {2'b01, 5'd10}) begin
         errors++; $display("FAIL bp_full_commit: got %b expected 01_01010", {ms_if.ws_allowin, rf_we, rf_waddr});
      end
      tick();
      #1;
      checks++;
      if ({ms_if.ws_allowin, ws_count, rf_waddr} !== {3'b101, 5'd11}) begin
         errors++; $display("FAIL bp_second: got %b expected 101_01011", {ms_if.ws_allowin, ws_count, rf_waddr});
      end
      tick();
      offer(1'b0, '0);
      #1;
      checks++;
      if ({rf_we, ws_count, rf_waddr} !== {3'b101, 5'd12}) begin
         errors++; $display("FAIL bp_wrap: got %b expected 101_01100", {rf_we, ws_count, rf_waddr});
      end
      tick();
      #1;
      checks++;
      if (ws_count !== 2'd0) begin
         errors++; $display("FAIL bp_drain: got count=%0d expected 0", ws_count);
      end
   endtask

   task automatic test_exception();
      ent_t a, b, d;
      a = mk(20); a.exc = 6'b001100;
      b = mk(21);
      d = mk(22); d.exc = 6'b100000;
      commit_ready = 1'b0;
      offer(1'b1, a); tick();
      offer(1'b1, b); tick();
      commit_ready = 1'b1;
      offer(1'b1, mk(23));
      #1;
      checks++;
      if ({wb_ex, ertn_flush, wb_refetch_flush, rf_we, wb_ecode, wb_esubcode} !== {4'b1000, 6'h9, 9'd0}) begin
         errors++; $display("FAIL exc_ale: got ex/ertn/ref/we=%b ecode=%h sub=%h expected 1000 ecode=09 sub=0",
                            {wb_ex, ertn_flush, wb_refetch_flush, rf_we}, wb_ecode, wb_esubcode);
      end
      checks++;
      if (wb_pc !== a.pc || wb_vaddr !== a.vaddr) begin
         errors++; $display("FAIL exc_pc: got pc=%h vaddr=%h expected pc=%h vaddr=%h", wb_pc, wb_vaddr, a.pc, a.vaddr);
      end
      tick();
      offer(1'b0, '0);
      commit_ready = 1'b0;
      #1;
      checks++;
      if ({ws_count, wb_ex} !== 3'b000) begin
         errors++; $display("FAIL exc_discard: got count=%0d ex=%b expected 0 0", ws_count, wb_ex);
      end
      offer(1'b1, d); tick();
      commit_ready = 1'b1;
      offer(1'b1, mk(24));
      #1;
      checks++;
      if ({ms_if.ws_allowin, wb_ex, wb_ecode} !== {2'b11, 6'hd}) begin
         errors++; $display("FAIL exc_ine: got allowin=%b ex=%b ecode=%h expected 1 1 0d",
                            ms_if.ws_allowin, wb_ex, wb_ecode);
      end
      tick();
      offer(1'b0, '0);
      #1;
      checks++;
      if ({ws_count, wb_ex} !== 3'b000) begin
         errors++; $display("FAIL exc_offer_dropped: got count=%0d ex=%b expected 0 0", ws_count, wb_ex);
      end
   endtask

   task automatic test_ertn_refetch();
      ent_t e;
      e = mk(25); e.ertn = 1'b1; e.refetch = 1'b1;
      commit_ready = 1'b0;
      offer(1'b1, e); tick();
      offer(1'b0, '0);
      commit_ready = 1'b1;
      #1;
      checks++;
      if ({ertn_flush, wb_refetch_flush, wb_ex, rf_we} !== 4'b1000) begin
         errors++; $display("FAIL ertn_prec: got ertn/ref/ex/we=%b expected 1000",
                            {ertn_flush, wb_refetch_flush, wb_ex, rf_we});
      end
      tick();
      #1;
      checks++;
      if ({ertn_flush, ws_count} !== 3'b000) begin
         errors++; $display("FAIL ertn_clear: got %b expected 000", {ertn_flush, ws_count});
      end
      e = mk(26); e.refetch = 1'b1;
      offer(1'b1, e); tick();
      offer(1'b0, '0);
      #1;
      checks++;
      if ({wb_refetch_flush, ertn_flush, wb_ex, rf_we} !== 4'b1001) begin
         errors++; $display("FAIL refetch: got ref/ertn/ex/we=%b expected 1001",
                            {wb_refetch_flush, ertn_flush, wb_ex, rf_we});
      end
      tick();
      #1;
      checks++;
      if ({wb_refetch_flush, ws_count} !== 3'b000) begin
         errors++; $display("FAIL refetch_pulse: got %b expected 000", {wb_refetch_flush, ws_count});
      end
   endtask

   task automatic test_csr_merge();
      ent_t e;
      e = mk(27); e.csr = 1'b1; e.wdata = 32'hdead;
      commit_ready = 1'b0;
      offer(1'b1, e); tick();
      offer(1'b0, '0);
      csr_rvalue = 32'h1234;
      #1;
      checks++;
      if ({csr_re, rf_we} !== 2'b10 || rf_wdata !== 32'h1234) begin
         errors++; $display("FAIL csr_hold: got csr_re=%b we=%b wdata=%h expected 1 0 1234", csr_re, rf_we, rf_wdata);
      end
      commit_ready = 1'b1;
      #1;
      checks++;
      if (rf_we !== 1'b1 || debug_wb_rf_wdata !== 32'h1234 || debug_wb_rf_wnum !== 5'd27) begin
         errors++; $display("FAIL csr_commit: got we=%b data=%h wnum=%0d expected 1 1234 27",
                            rf_we, debug_wb_rf_wdata, debug_wb_rf_wnum);
      end
      tick();
      #1;
      checks++;
      if (csr_re !== 1'b0) begin
         errors++; $display("FAIL csr_empty: got csr_re=%b expected 0", csr_re);
      end
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         ent_t e, h;
         bit   hv, cm, ex;
         e = mk(cyc);
         e.we      = ($urandom_range(0, 7) != 0);
         e.csr     = ($urandom_range(0, 3) == 0);
         e.exc     = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
         e.ertn    = ($urandom_range(0, 11) == 0);
         e.refetch = ($urandom_range(0, 11) == 0);
         offer($urandom_range(0, 9) < 7, e);
         commit_ready = ($urandom_range(0, 9) < 6);
         csr_rvalue   = $urandom;
         #1;
         hv = (mq.size() != 0);
         h  = hv ? mq[0] : '0;
         cm = hv && commit_ready;
         ex = (h.exc != 0);
         checks++;
         if ({ms_if.ws_allowin, ws_count} !== {mq.size() < DEPTH, 2'(mq.size())}) begin
            errors++; $display("FAIL rand_occ cyc%0d: got allowin/count=%b expected size %0d",
                               cyc, {ms_if.ws_allowin, ws_count}, mq.size());
         end
         checks++;
         if ({wb_ex, ertn_flush, wb_refetch_flush, rf_we, csr_re} !==
             {cm && ex, cm && h.ertn && !ex, cm && h.refetch && !ex && !h.ertn,
              cm && h.we && !ex && !h.ertn, hv && h.csr}) begin
            errors++; $display("FAIL rand_pulses cyc%0d: got ex/ertn/ref/we/csr=%b head exc=%b ertn=%b ref=%b",
                               cyc, {wb_ex, ertn_flush, wb_refetch_flush, rf_we, csr_re}, h.exc, h.ertn, h.refetch);
         end
         checks++;
         if ({wb_pc, wb_vaddr, wb_ecode} !== (hv ? {h.pc, h.vaddr, exp_ecode(h.exc)} : 70'd0)) begin
            errors++; $display("FAIL rand_head cyc%0d: got pc=%h vaddr=%h ecode=%h expected pc=%h vaddr=%h ecode=%h",
                               cyc, wb_pc, wb_vaddr, wb_ecode, h.pc, h.vaddr, hv ? exp_ecode(h.exc) : 6'd0);
         end
         if (hv) begin
            checks++;
            if (rf_waddr !== h.waddr || rf_wdata !== (h.csr ? csr_rvalue : h.wdata)) begin
               errors++; $display("FAIL rand_data cyc%0d: got addr=%0d data=%h expected addr=%0d data=%h",
                                  cyc, rf_waddr, rf_wdata, h.waddr, h.csr ? csr_rvalue : h.wdata);
            end
         end
         tick();
      end
   endtask

   task automatic test_reset_midop();
      commit_ready = 1'b0;
      offer(1'b1, mk(28)); tick();
      offer(1'b1, mk(29)); tick();
      commit_ready = 1'b1;
      offer(1'b1, mk(30));
      #1;
      resetn = 1'b0;
      mq.delete();
      #1;
      checks++;
      if ({ms_if.ws_allowin, ws_count, wb_ex, ertn_flush, wb_refetch_flush, rf_we, csr_re} !== 8'b10000000) begin
         errors++; $display("FAIL reset_midop: got %b expected 10000000",
                            {ms_if.ws_allowin, ws_count, wb_ex, ertn_flush, wb_refetch_flush, rf_we, csr_re});
      end
      #1;
      resetn = 1'b1;
      offer(1'b0, '0);
      tick();
      #1;
      checks++;
      if ({ws_count, rf_we} !== 3'b000) begin
         errors++; $display("FAIL reset_midop_after: got %b expected 000", {ws_count, rf_we});
      end
   endtask

   initial begin
      resetn = 1'b0;
      commit_ready = 1'b0;
      csr_rvalue = '0;
      offer(1'b0, '0);
      @(negedge clk);
      test_reset();
      test_streaming();
      test_backpressure();
      test_exception();
      test_ertn_refetch();
      test_csr_merge();
      test_random();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/wb_commit_queue.md
# wb_commit_queue

Parametrised writeback stage that replaces the single-register WB stage with a DEPTH-entry in-order commit queue between MEM and the register file/CSR unit. Each entry retires from the head when the downstream commit port is ready. Exceptions are encoded through a configurable priority table. A faulting, `ertn` or refetch entry at the head raises the matching one-cycle flush and discards every younger entry in the queue.

## Interface
- DEPTH, 2: queue entries; power of two, ≥2.
- DATA_W, 32: register write-data width.
- NEXC, 6: number of exception source bits; bit 0 has the highest priority.
- ECODE_TAB, {6'hd,6'hc,6'hb,6'h9,6'h8,6'h0}: NEXC×6 bits; ECODE_TAB[6*i+:6] is the ecode for source i (default order: int, adef, ale, sys, brk, ine).

- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- ms2ws_valid  in  1  MEM offers an entry.
- ws_allowin  out  1  queue accepts an entry this cycle.
- ms_pc / ms_vaddr  in  32 each  entry PC / faulting vaddr.
- ms_rf_we, ms_rf_waddr, ms_rf_wdata  in  1/5/DATA_W  register write request.
- ms_csr_re  in  1  write data comes from a CSR read.
- ms_exc  in  NEXC  exception source vector.
- ms_ertn, ms_refetch  in  1 each  ertn instruction / refetch-after-TLB-op marker.
- commit_ready  in  1  downstream accepts the head this cycle.
- csr_re  out  1  head is valid and needs a CSR read.
- csr_rvalue  in  DATA_W  CSR read data, combinational.
- rf_we, rf_waddr, rf_wdata  out  1/5/DATA_W  register file write port.
- debug_wb_pc  out  32;  debug_wb_rf_we  out  4;  debug_wb_rf_wnum  out  5;  debug_wb_rf_wdata  out  DATA_W.
- wb_ex, ertn_flush, wb_refetch_flush  out  1 each  one-cycle flush pulses.
- wb_ecode  out  6;  wb_esubcode  out  9;  wb_pc, wb_vaddr  out  32 each.
- ws_count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage is a circular buffer with head and tail pointers ($clog2(DEPTH) bits, natural wrap) and a count register. Each entry holds {pc, vaddr, rf_we, waddr, wdata, csr_re, exc, ertn, refetch}.
- Push occurs when ms2ws_valid & ws_allowin & ~flush. ws_allowin = (count != DEPTH); it does not depend on same-cycle pop.
- head_valid = (count != 0). Commit occurs when head_valid & commit_ready.
- Exception encoding: the lowest set index i in the head's exc vector selects wb_ecode = ECODE_TAB[6*i+:6]. wb_ecode is 0 if no bit is set. wb_esubcode is always 0.
- Commit outputs are combinational from the head and the commit condition:
  - wb_ex = commit & |exc.
  - ertn_flush = commit & ertn & ~|exc.
  - wb_refetch_flush = commit & refetch & ~|exc & ~ertn.
  - flush = OR of these three.
- rf_we = commit & head.rf_we & ~|exc & ~ertn.
- rf_wdata = head.csr_re ? csr_rvalue : head.wdata.
- The debug outputs mirror the rf port: debug_wb_rf_we = {4{rf_we}}, debug_wb_pc = head.pc.
- wb_pc and wb_vaddr present the head fields whenever head_valid, and 0 otherwise.
- Flush: on the next edge, count, head and tail go to 0. The entry offered in the flush cycle is not pushed.
- Non-flushing commit advances head by 1. Push advances tail by 1. Simultaneous push and pop leaves count unchanged.

## Timing
- Reset (asynchronous, resetn=0): count, head and tail are 0 and entries are cleared. Every output is 0 except ws_allowin=1.
- Push-to-commit latency: 1 cycle minimum. An entry pushed at edge N is at the head from N and can commit in the cycle after N when the queue was empty.
- Throughput: one commit per cycle while commit_ready=1.
- Full (count=DEPTH): ws_allowin=0. If the head commits that cycle, an entry is still not accepted until the next cycle.
- Empty: no output pulses; csr_re=0; rf_we=0.
- Flush pulses last exactly one cycle because the queue is cleared at the same edge.
- Reset asserted mid-operation aborts all entries immediately, with no commit or flush pulse.

## Test plan
- **Reset/idle:** hold resetn=0, then release. Expect ws_allowin=1, ws_count=0, and all pulses 0 until the first push.
- **Streaming:** push 8 entries with rf_we=1, waddr=i, wdata=0x100+i, commit_ready=1. Expect 8 rf writes in order, one per cycle, with ws_count ≤1.
- **Backpressure/wrap:** hold commit_ready=0 and push 3 entries (DEPTH=2). Expect the third to be refused (ws_allowin=0, ws_count=2). Release commit_ready. Expect in-order commit across the pointer wrap.
- **Exception priority:** head exc=6'b001100. Expect wb_ex=1, wb_ecode=0x9, rf_we=0. The younger queued entry is discarded, ws_count=0 next cycle, and the entry offered in that cycle is not accepted.
- **ertn/refetch precedence:** head with ertn=1 and refetch=1 and no exception gives ertn_flush=1, wb_refetch_flush=0. Head with refetch only gives wb_refetch_flush=1 for one cycle.
- **CSR read merge:** head csr_re=1, wdata=0xdead, csr_rvalue=0x1234. Expect csr_re=1 and rf_wdata=0x1234.
